// File: rtl/cart_mem_responder.sv
// Memory-side responder for a cartridge slot: turns one mapped Z80 access per
// MREQ cycle into a req/ack transaction on the shared ROM/SRAM store, stretches
// the CPU cycle with WAIT and returns read data to the slot data mux.
module cart_mem_responder #(
    parameter logic [24:0] ROM_BASE  = 25'h0000000,
    parameter logic [24:0] SRAM_BASE = 25'h1F00000,
    parameter int          SRAM_AW   = 13,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        cpu_mreq,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  din,
    input  logic [24:0] mem_addr,
    input  logic        mem_unmaped,
    input  logic        sram_cs,
    input  logic        sram_we,
    output logic [7:0]  dout,
    output logic        dout_oe,
    output logic        wait_n,
    output logic        ext_req,
    output logic        ext_we,
    output logic [24:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  dout_q, dout_d;
    logic        dout_oe_q, dout_oe_d;
    logic        ext_req_q, ext_req_d;
    logic        ext_we_q, ext_we_d;
    logic [24:0] ext_addr_q, ext_addr_d;
    logic [7:0]  ext_wdata_q, ext_wdata_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        is_rd_q, is_rd_d;

    logic        start;
    logic        start_to_busy;
    logic [24:0] sram_addr;
    logic [24:0] rom_addr;

    // Byte addresses into the external store; sums wrap modulo 2^25.
    assign sram_addr = SRAM_BASE + {{(25 - SRAM_AW){1'b0}}, mem_addr[SRAM_AW-1:0]};
    assign rom_addr  = ROM_BASE + mem_addr;

    // A new access may only begin from IDLE; reset suppresses it so the
    // reset edge cannot launch a transaction.
    assign start = ~reset & (state_q == IDLE) & cs & cpu_mreq & (cpu_rd | cpu_wr);

    // Next-state and output decode for the access sequencer.
    always_comb begin
        state_d       = state_q;
        dout_d        = dout_q;
        dout_oe_d     = dout_oe_q;
        ext_req_d     = ext_req_q;
        ext_we_d      = ext_we_q;
        ext_addr_d    = ext_addr_q;
        ext_wdata_d   = ext_wdata_q;
        err_d         = 1'b0;
        cnt_d         = cnt_q;
        is_rd_d       = is_rd_q;
        start_to_busy = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (start) begin
                    if (mem_unmaped) begin
                        // Unmapped: open bus reads as 0xFF, writes vanish.
                        state_d = HOLD;
                        if (cpu_rd) begin
                            dout_d    = 8'hFF;
                            dout_oe_d = 1'b1;
                        end
                    end else if (cpu_rd) begin
                        start_to_busy = 1'b1;
                        ext_addr_d    = sram_cs ? sram_addr : rom_addr;
                        ext_we_d      = 1'b0;
                    end else if (sram_cs && sram_we) begin
                        start_to_busy = 1'b1;
                        ext_addr_d    = sram_addr;
                        ext_we_d      = 1'b1;
                        ext_wdata_d   = din;
                    end else begin
                        // ROM (bank register) writes are the mapper's business.
                        state_d = HOLD;
                    end
                    if (start_to_busy) begin
                        state_d   = BUSY;
                        ext_req_d = 1'b1;
                        is_rd_d   = cpu_rd;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (ext_ack) begin
                    ext_req_d = 1'b0;
                    state_d   = HOLD;
                    if (is_rd_q) begin
                        dout_d    = ext_rdata;
                        dout_oe_d = 1'b1;
                    end
                end else if ((cnt_q + 8'd1) == TIMEOUT_L) begin
                    ext_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = HOLD;
                    if (is_rd_q) begin
                        dout_d    = 8'hFF;
                        dout_oe_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                // One access per MREQ: wait for the CPU to end the cycle.
                if (!cpu_mreq) begin
                    state_d   = IDLE;
                    dout_oe_d = 1'b0;
                    cnt_d     = 8'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            dout_q      <= 8'hFF;
            dout_oe_q   <= 1'b0;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= 25'd0;
            ext_wdata_q <= 8'd0;
            err_q       <= 1'b0;
            cnt_q       <= 8'd0;
            is_rd_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dout_q      <= dout_d;
            dout_oe_q   <= dout_oe_d;
            ext_req_q   <= ext_req_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            is_rd_q     <= is_rd_d;
        end
    end

    // WAIT is combinational so the CPU is stalled in the very cycle the access starts.
    assign wait_n    = ~(start_to_busy | (state_q == BUSY));
    assign dout      = dout_q;
    assign dout_oe   = dout_oe_q;
    assign ext_req   = ext_req_q;
    assign ext_we    = ext_we_q;
    assign ext_addr  = ext_addr_q;
    assign ext_wdata = ext_wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cart_mem_responder.sv
// Directed bench for cart_mem_responder: ROM/SRAM/unmapped accesses,
// one-access-per-MREQ, timeout and reset in the middle of an access.
module tb_cart_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, cpu_mreq, cpu_rd, cpu_wr;
    logic [7:0]  din;
    logic [24:0] mem_addr;
    logic        mem_unmaped, sram_cs, sram_we;
    logic [7:0]  dout;
    logic        dout_oe, wait_n, ext_req, ext_we;
    logic [24:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_ack;
    logic [7:0]  ext_rdata;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int req_cnt  = 0;
    int err_cnt  = 0;

    cart_mem_responder #(
        .ROM_BASE (25'h0000000),
        .SRAM_BASE(25'h1F00000),
        .SRAM_AW  (13),
        .TIMEOUT  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .cpu_mreq   (cpu_mreq),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .din        (din),
        .mem_addr   (mem_addr),
        .mem_unmaped(mem_unmaped),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .dout       (dout),
        .dout_oe    (dout_oe),
        .wait_n     (wait_n),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_ack    (ext_ack),
        .ext_rdata  (ext_rdata),
        .err        (err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Count ext_req rising edges and err pulses at the clock.
    logic ext_req_prev = 1'b0;
    always @(posedge clk) begin
        if (ext_req && !ext_req_prev) req_cnt++;
        if (err) err_cnt++;
        ext_req_prev <= ext_req;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        cs = 1'b1; cpu_mreq = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        mem_unmaped = 1'b0; sram_cs = 1'b0; sram_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; din = 8'h00; mem_addr = 25'd0;
        ext_ack = 1'b0; ext_rdata = 8'h00;
        idle_bus();
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_dout", 32'(dout), 32'hFF);
        check("rst_oe", 32'(dout_oe), 32'd0);
        check("rst_wait", 32'(wait_n), 32'd1);
        check("rst_req", 32'(ext_req), 32'd0);
        check("rst_addr", 32'(ext_addr), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // 1: ROM read with ack three cycles after the request.
        cpu_mreq = 1'b1; cpu_rd = 1'b1; mem_addr = 25'h12345;
        #1;
        check("t1_wait_start", 32'(wait_n), 32'd0);
        tick();
        check("t1_req", 32'(ext_req), 32'd1);
        check("t1_addr", 32'(ext_addr), 32'h12345);
        check("t1_we", 32'(ext_we), 32'd0);
        check("t1_wait_busy", 32'(wait_n), 32'd0);
        tick(); tick(); tick();
        check("t1_req_held", 32'(ext_req), 32'd1);
        check("t1_wait_held", 32'(wait_n), 32'd0);
        ext_ack = 1'b1; ext_rdata = 8'hA5;
        tick();
        ext_ack = 1'b0; ext_rdata = 8'h00;
        check("t1_req_drop", 32'(ext_req), 32'd0);
        check("t1_wait_rel", 32'(wait_n), 32'd1);
        check("t1_dout", 32'(dout), 32'hA5);
        check("t1_oe", 32'(dout_oe), 32'd1);
        tick();
        check("t1_oe_hold", 32'(dout_oe), 32'd1);
        check("t1_dout_hold", 32'(dout), 32'hA5);
        idle_bus();
        tick();
        check("t1_oe_off", 32'(dout_oe), 32'd0);
        check("t1_dout_keep", 32'(dout), 32'hA5);
        check("t1_one_req", 32'(req_cnt), 32'd1);

        // 2: SRAM write, address truncated to 13 bits.
        cpu_mreq = 1'b1; cpu_wr = 1'b1; sram_cs = 1'b1; sram_we = 1'b1;
        mem_addr = 25'h3FFF; din = 8'h5A;
        tick();
        check("t2_req", 32'(ext_req), 32'd1);
        check("t2_addr", 32'(ext_addr), 32'h1F01FFF);
        check("t2_we", 32'(ext_we), 32'd1);
        check("t2_wdata", 32'(ext_wdata), 32'h5A);
        ext_ack = 1'b1;
        tick();
        ext_ack = 1'b0;
        check("t2_req_drop", 32'(ext_req), 32'd0);
        check("t2_oe", 32'(dout_oe), 32'd0);
        check("t2_wait", 32'(wait_n), 32'd1);
        idle_bus();
        tick();

        // 3: Unmapped read.
        cpu_mreq = 1'b1; cpu_rd = 1'b1; mem_unmaped = 1'b1; mem_addr = 25'h4000;
        #1;
        check("t3_wait_start", 32'(wait_n), 32'd1);
        tick();
        check("t3_dout", 32'(dout), 32'hFF);
        check("t3_oe", 32'(dout_oe), 32'd1);
        check("t3_wait", 32'(wait_n), 32'd1);
        check("t3_req", 32'(ext_req), 32'd0);
        tick();
        check("t3_no_req", 32'(req_cnt), 32'd2);
        idle_bus();
        tick();

        // 4: ROM write is dropped; a new access needs MREQ to toggle.
        cpu_mreq = 1'b1; cpu_wr = 1'b1; mem_addr = 25'h07FF; din = 8'h11;
        #1;
        check("t4_wait_start", 32'(wait_n), 32'd1);
        tick();
        check("t4_req", 32'(ext_req), 32'd0);
        cpu_wr = 1'b0; cpu_rd = 1'b1;
        #1;
        check("t4_no_restart", 32'(wait_n), 32'd1);
        tick(); tick();
        check("t4_req_still", 32'(ext_req), 32'd0);
        cpu_mreq = 1'b0;
        tick();
        cpu_mreq = 1'b1;
        #1;
        check("t4_restart_wait", 32'(wait_n), 32'd0);
        tick();
        check("t4_req2", 32'(ext_req), 32'd1);
        check("t4_addr2", 32'(ext_addr), 32'h07FF);
        ext_ack = 1'b1; ext_rdata = 8'h3C;
        tick();
        ext_ack = 1'b0;
        check("t4_dout", 32'(dout), 32'h3C);
        idle_bus();
        tick();

        // 5: Timeout with TIMEOUT = 4 and no ack.
        cpu_mreq = 1'b1; cpu_rd = 1'b1; mem_addr = 25'h100;
        tick();
        check("t5_req", 32'(ext_req), 32'd1);
        tick(); tick(); tick();
        check("t5_req_c4", 32'(ext_req), 32'd1);
        check("t5_err_early", 32'(err), 32'd0);
        tick();
        check("t5_req_drop", 32'(ext_req), 32'd0);
        check("t5_err", 32'(err), 32'd1);
        check("t5_dout", 32'(dout), 32'hFF);
        check("t5_oe", 32'(dout_oe), 32'd1);
        check("t5_wait", 32'(wait_n), 32'd1);
        tick();
        check("t5_err_pulse", 32'(err), 32'd0);
        idle_bus();
        tick();

        // 6: Reset two cycles into BUSY, then a late ack.
        cpu_mreq = 1'b1; cpu_rd = 1'b1; mem_addr = 25'h200;
        tick(); tick(); tick();
        check("t6_busy", 32'(wait_n), 32'd0);
        reset = 1'b1; idle_bus();
        tick();
        reset = 1'b0;
        check("t6_req", 32'(ext_req), 32'd0);
        check("t6_wait", 32'(wait_n), 32'd1);
        ext_ack = 1'b1; ext_rdata = 8'h77;
        tick();
        ext_ack = 1'b0;
        check("t6_dout", 32'(dout), 32'hFF);
        check("t6_oe", 32'(dout_oe), 32'd0);
        check("t6_req_after", 32'(ext_req), 32'd0);
        cpu_mreq = 1'b1; cpu_rd = 1'b1; mem_addr = 25'h300;
        #1;
        check("t6_idle", 32'(wait_n), 32'd0);
        tick();
        check("t6_addr", 32'(ext_addr), 32'h300);
        ext_ack = 1'b1; ext_rdata = 8'h42;
        tick();
        ext_ack = 1'b0;
        check("t6_dout2", 32'(dout), 32'h42);
        idle_bus();
        tick();
        check("err_count", 32'(err_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cart_mem_responder.md
Name: cart_mem_responder

Overview:
- Memory-side responder for the cartridge slot mappers.
- Takes one mapped CPU access per MREQ cycle, described by the mapper's mem_addr, mem_unmaped, sram_cs and sram_we outputs, and serves it over a req/ack port to the shared ROM/SRAM store.
- Stretches the Z80 cycle with wait_n and returns read data to the slot data mux.
- Unmapped reads return 0xFF with no memory traffic.

Parameters:
- ROM_BASE, 25'h0000000, byte offset of the cartridge ROM image in the external store.
- SRAM_BASE, 25'h1F00000, byte offset of the cartridge battery SRAM in the external store.
- SRAM_AW, 13, SRAM address width; mem_addr is truncated to this width for SRAM accesses.
- TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting; range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cs  in  1  slot/subslot select for this cartridge
- cpu_mreq  in  1  Z80 memory request
- cpu_rd  in  1  Z80 read strobe
- cpu_wr  in  1  Z80 write strobe
- din  in  8  CPU write data
- mem_addr  in  25  mapped address from the mapper
- mem_unmaped  in  1  mapper reports unmapped region
- sram_cs  in  1  mapper selects SRAM
- sram_we  in  1  mapper SRAM write qualifier
- dout  out  8  read data to CPU
- dout_oe  out  1  drive dout onto the slot bus
- wait_n  out  1  Z80 WAIT, active low
- ext_req  out  1  external memory request (level)
- ext_we  out  1  external write enable
- ext_addr  out  25  external byte address
- ext_wdata  out  8  external write data
- ext_ack  in  1  one-cycle completion pulse
- ext_rdata  in  8  read data, valid with ext_ack
- err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset values:
  - State IDLE.
  - dout = 8'hFF, dout_oe = 0, wait_n = 1.
  - ext_req = 0, ext_we = 0, ext_addr = 0, ext_wdata = 0, err = 0.
  - Timeout counter = 0.
- start = IDLE & cs & cpu_mreq & (cpu_rd | cpu_wr).
- At most one access is served per cpu_mreq assertion. After any access the FSM waits in HOLD for cpu_mreq = 0.
- Decode at start:
  - mem_unmaped & cpu_rd: go to HOLD. Set dout = 8'hFF and dout_oe = 1. No ext traffic. wait_n stays 1.
  - mem_unmaped & cpu_wr: go to HOLD. Write is ignored. No ext traffic.
  - sram_cs & cpu_rd: go to BUSY. ext_addr = SRAM_BASE + zero-extended mem_addr[SRAM_AW-1:0]. ext_we = 0.
  - sram_we (write): go to BUSY with the same address. ext_we = 1, ext_wdata = din.
  - ROM read (cs & ~sram_cs & ~mem_unmaped & cpu_rd): go to BUSY. ext_addr = ROM_BASE + mem_addr. ext_we = 0.
  - ROM write: go to HOLD with no ext traffic. Bank registers belong to the mapper.
- Address sums are modulo 2^25 and wrap silently.
- wait_n = ~(start_to_busy | BUSY). It is combinational so the Z80 sees WAIT in the same cycle the access begins.
- BUSY state:
  - ext_req is registered high from the cycle after start.
  - ext_addr, ext_we and ext_wdata are held stable while ext_req = 1.
  - The timeout counter increments each cycle.
  - On ext_ack: drop ext_req and go to HOLD. For a read, latch dout = ext_rdata and set dout_oe = 1. wait_n returns to 1 in the same cycle.
  - If the counter reaches TIMEOUT without ext_ack: drop ext_req and pulse err for one cycle. Reads return dout = 8'hFF with dout_oe = 1. Go to HOLD.
  - An ext_ack arriving while not in BUSY is ignored.
- HOLD state:
  - dout and dout_oe are held.
  - When cpu_mreq = 0, go to IDLE with dout_oe = 0. dout keeps its last value.
  - The counter clears on entry to IDLE.
- Read latency: the ext request is issued 1 cycle after start. Data reaches the CPU on the ack cycle plus 1.
- If cs drops during BUSY, the access completes normally.
- Reset mid-access: ext_req = 0 and wait_n = 1 at the next edge. A late ext_ack is ignored.

Test Plan:
1. ROM read, cs = 1, mem_addr = 25'h12345, ROM_BASE = 0, ext_ack 3 cycles after ext_req, ext_rdata = 8'hA5 -> ext_addr = 25'h12345, ext_we = 0. wait_n low from the start cycle until ack. dout = 8'hA5 with dout_oe = 1 until cpu_mreq falls. Exactly one ext_req.
2. SRAM write, sram_cs = sram_we = 1, mem_addr = 25'h3FFF, din = 8'h5A, SRAM_AW = 13 -> ext_addr = SRAM_BASE + 25'h1FFF, ext_we = 1, ext_wdata = 8'h5A, dout_oe = 0.
3. Unmapped read, mem_unmaped = 1 -> dout = 8'hFF, dout_oe = 1, wait_n never low, ext_req never asserted.
4. ROM write, mem_addr = 25'h07FF -> no ext_req, wait_n stays 1. A second access starts only after cpu_mreq toggles 0 -> 1.
5. Timeout, TIMEOUT = 4, ext_ack never asserted -> ext_req drops after 4 cycles, err pulses once, dout = 8'hFF, wait_n returns to 1.
6. Reset asserted 2 cycles into BUSY, then ext_ack pulses -> ext_req = 0 and wait_n = 1 after the reset edge. The ack is ignored and the FSM is in IDLE.
